// File: rtl/toggle_xfer_arb_if.sv
// Bundle of the requester side and far-domain toggle channel of toggle_xfer_arb.
// The arbiter connects through the slave modport; the requester/far-side model uses master.
interface toggle_xfer_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic                     ack_tgl_async;
  logic                     xfer_tgl;
  logic [WIDTH-1:0]         xfer_data;
  logic [SRC_W-1:0]         xfer_src;
  logic                     busy;
  logic [NUM_REQ-1:0]       done;

  modport master (
    output req, req_data, ack_tgl_async,
    input  xfer_tgl, xfer_data, xfer_src, busy, done
  );

  modport slave (
    input  req, req_data, ack_tgl_async,
    output xfer_tgl, xfer_data, xfer_src, busy, done
  );
endinterface

// File: rtl/toggle_xfer_arb.sv
// Round-robin front end sharing one toggle-handshake clock-crossing channel among
// NUM_REQ requesters; one transfer in flight, released by the synchronised echo toggle.
module toggle_xfer_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  toggle_xfer_arb_if.slave    bus
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t             state, state_nxt;
  logic               ack_s1, ack_s;
  logic [SRC_W-1:0]   ptr;
  logic               xfer_tgl;
  logic [WIDTH-1:0]   xfer_data;
  logic [SRC_W-1:0]   xfer_src;
  logic               busy;
  logic [NUM_REQ-1:0] done;

  logic               launch, finish;
  logic               win_vld;
  logic [SRC_W-1:0]   win_idx;
  logic [WIDTH-1:0]   win_data;
  logic [SRC_W-1:0]   ptr_nxt;
  logic [NUM_REQ-1:0] done_nxt;

  // First asserted request at or after p, wrapping; MSB flags that one was found.
  function automatic logic [SRC_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [SRC_W-1:0]   p);
    logic [SRC_W:0] res;
    int             idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NUM_REQ;
      if (r[idx]) res = {1'b1, SRC_W'(idx)};
    end
    return res;
  endfunction

  // Far-domain acknowledge toggle enters through a 2-flop synchroniser only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_s1 <= 1'b0;
      ack_s  <= 1'b0;
    end else begin
      ack_s1 <= bus.ack_tgl_async;
      ack_s  <= ack_s1;
    end
  end

  always_comb begin
    {win_vld, win_idx} = rr_pick(bus.req, ptr);
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win_idx == SRC_W'(i)) win_data = bus.req_data[i*WIDTH +: WIDTH];
    ptr_nxt = (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    finish    = 1'b0;
    done_nxt  = '0;
    case (state)
      IDLE: begin
        // An ack mismatch here is a far-side violation and is deliberately ignored
        if (win_vld) begin
          launch    = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s == xfer_tgl) begin
          finish    = 1'b1;
          done_nxt  = NUM_REQ'(1) << xfer_src;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      xfer_tgl  <= 1'b0;
      xfer_data <= '0;
      xfer_src  <= '0;
      busy      <= 1'b0;
      done      <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      // Payload and toggle move together; the far side samples data only after syncing the toggle
      if (launch) begin
        xfer_data <= win_data;
        xfer_src  <= win_idx;
        xfer_tgl  <= ~xfer_tgl;
        busy      <= 1'b1;
        ptr       <= ptr_nxt;
      end else if (finish) begin
        busy <= 1'b0;
      end
    end
  end

  assign bus.xfer_tgl  = xfer_tgl;
  assign bus.xfer_data = xfer_data;
  assign bus.xfer_src  = xfer_src;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule
